// File: rtl/fetch_stage.sv
// fetch_stage: 16-bit instruction fetch front end.
// Keeps at most one memory read outstanding, buffers one response in a skid
// entry while decode stalls, squashes in-flight responses on redirect, and
// stops permanently on halt.
// Optional HLT predecode is enabled by defining FETCH_HLT_PREDECODE_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branching,
  input  logic [15:0] next_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instruction,
  output logic [15:0] f_pc_plus2,
  output logic        f_valid,
  output logic        halted
);

`ifdef FETCH_HLT_PREDECODE_EN
  localparam logic PREDECODE = 1'b1;
`else
  localparam logic PREDECODE = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_REQ,
    ST_SQUASH,
    ST_HALT
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] instr_n, pc2_n;
  logic        valid_n;
  logic        skid_valid, skid_valid_n;
  logic [15:0] skid_data, skid_data_n;
  logic [15:0] skid_pc2, skid_pc2_n;
  logic        run;
  logic        accept;
  logic [15:0] pc_inc;
  logic        rdata_hlt;
  logic        skid_hlt;

  // run holds the request off while reset is asserted; the first request goes
  // out in the cycle after the first clock edge with rst low.
  assign imem_req  = run && (state == ST_REQ) && !skid_valid;
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);
  assign accept    = imem_req && imem_valid;
  assign pc_inc    = pc + 16'd2;
  assign rdata_hlt = PREDECODE && (imem_rdata[15:12] == 4'hF);
  assign skid_hlt  = PREDECODE && (skid_data[15:12] == 4'hF);

  // State, PC, skid entry and the registered decode-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      instruction <= '0;
      f_pc_plus2  <= '0;
      f_valid     <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_pc2    <= '0;
      run         <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instr_n;
      f_pc_plus2  <= pc2_n;
      f_valid     <= valid_n;
      skid_valid  <= skid_valid_n;
      skid_data   <= skid_data_n;
      skid_pc2    <= skid_pc2_n;
      run         <= 1'b1;
    end
  end

  // Next-state and next-output selection; halt takes priority over everything.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    instr_n      = instruction;
    pc2_n        = f_pc_plus2;
    valid_n      = f_valid;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_pc2_n   = skid_pc2;

    if (halt) begin
      state_n      = ST_HALT;
      instr_n      = '0;
      valid_n      = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      unique case (state)
        ST_REQ: begin
          if (!stall && branching) begin
            // A request still waiting for its response must have that
            // response thrown away before fetching from the new target.
            pc_n         = next_pc;
            instr_n      = '0;
            valid_n      = 1'b0;
            skid_valid_n = 1'b0;
            state_n      = (imem_req && !imem_valid) ? ST_SQUASH : ST_REQ;
          end else if (stall) begin
            // Outputs frozen; a response landing now is parked in the skid.
            if (accept) begin
              skid_valid_n = 1'b1;
              skid_data_n  = imem_rdata;
              skid_pc2_n   = pc_inc;
              pc_n         = pc_inc;
            end
          end else if (skid_valid) begin
            instr_n      = skid_data;
            pc2_n        = skid_pc2;
            valid_n      = 1'b1;
            skid_valid_n = 1'b0;
            if (skid_hlt) state_n = ST_HALT;
          end else if (accept) begin
            instr_n = imem_rdata;
            pc2_n   = pc_inc;
            valid_n = 1'b1;
            pc_n    = pc_inc;
            if (rdata_hlt) state_n = ST_HALT;
          end else begin
            instr_n = '0;
            valid_n = 1'b0;
          end
        end
        ST_SQUASH: begin
          if (!stall && branching) pc_n = next_pc;
          if (imem_valid) state_n = ST_REQ;
          if (!stall) begin
            instr_n = '0;
            valid_n = 1'b0;
          end
        end
        ST_HALT: begin
          if (!stall) begin
            instr_n = '0;
            valid_n = 1'b0;
          end
        end
        default: state_n = ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a single-cycle memory
// model. A cycle table covers fetch, stall/skid, squash and redirect; hand
// sequences cover PC wrap, halt with branch, and HLT predecode.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branching = 1'b0;
  logic [15:0] next_pc = '0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [15:0] instruction;
  logic [15:0] f_pc_plus2;
  logic        f_valid;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branching  (branching),
    .next_pc    (next_pc),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .instruction(instruction),
    .f_pc_plus2 (f_pc_plus2),
    .f_valid    (f_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h0123;
      16'h0002: return 16'h4567;
      16'h0040: return 16'h1111;
      16'h0080: return 16'hF000;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  // Memory: accepts a request seen mid-cycle, answers with a one-cycle valid
  // pulse in the following cycle, and accepts nothing while answering.
  logic        pend = 1'b0;
  logic [15:0] pend_addr = '0;
  always @(negedge clk) begin
    if (rst) begin
      imem_valid = 1'b0;
      pend       = 1'b0;
    end else begin
      if (imem_valid) imem_valid = 1'b0;
      if (pend) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend       = 1'b0;
      end else if (imem_req) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; branching = 1'b0; halt = 1'b0; next_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_instr",  instruction, 16'h0000);
    chk("rst_pc2",    f_pc_plus2,  16'h0000);
    chk("rst_valid",  f_valid,     1'b0);
    chk("rst_req",    imem_req,    1'b0);
    chk("rst_addr",   imem_addr,   16'h0000);
    chk("rst_halted", halted,      1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        branching;
    logic        halt;
    logic [15:0] next_pc;
    logic [15:0] e_instr;
    logic [15:0] e_pc2;
    logic        e_valid;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_halted;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic h,
                              input logic [15:0] np, input logic [15:0] ei,
                              input logic [15:0] ep, input logic ev,
                              input logic er, input logic [15:0] ea,
                              input logic eh);
    vec_t v;
    v.stall = s; v.branching = b; v.halt = h; v.next_pc = np;
    v.e_instr = ei; v.e_pc2 = ep; v.e_valid = ev; v.e_req = er;
    v.e_addr = ea; v.e_halted = eh;
    return v;
  endfunction

  localparam int unsigned NVEC = 17;
  vec_t tbl[NVEC];

  initial begin
    // One row per cycle after reset release: inputs driven during that cycle,
    // outputs expected during that cycle.
    //             stl br  hlt next      instr     pc2       fv   req  addr      halted
    tbl[0]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0);
    tbl[2]  = mk(1, 0, 0, 16'h0000, 16'h0123, 16'h0002, 1, 1, 16'h0002, 0);
    tbl[3]  = mk(1, 0, 0, 16'h0000, 16'h0123, 16'h0002, 1, 1, 16'h0002, 0);
    tbl[4]  = mk(1, 0, 0, 16'h0000, 16'h0123, 16'h0002, 1, 0, 16'h0004, 0);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 16'h0123, 16'h0002, 1, 0, 16'h0004, 0);
    tbl[6]  = mk(0, 1, 0, 16'h0040, 16'h4567, 16'h0004, 1, 1, 16'h0004, 0);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 0, 16'h0040, 0);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 1, 16'h0040, 0);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 1, 16'h0040, 0);
    tbl[10] = mk(0, 0, 0, 16'h0000, 16'h1111, 16'h0042, 1, 1, 16'h0042, 0);
    tbl[11] = mk(0, 1, 0, 16'h0010, 16'h0000, 16'h0042, 0, 1, 16'h0042, 0);
    tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0042, 0, 1, 16'h0010, 0);
    tbl[13] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0042, 0, 1, 16'h0010, 0);
    tbl[14] = mk(1, 1, 0, 16'h0080, 16'hA5B5, 16'h0012, 1, 1, 16'h0012, 0);
    tbl[15] = mk(0, 0, 0, 16'h0000, 16'hA5B5, 16'h0012, 1, 1, 16'h0012, 0);
    tbl[16] = mk(0, 0, 0, 16'h0000, 16'hA5B7, 16'h0014, 1, 1, 16'h0014, 0);

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d_instr",  i + 1), instruction, tbl[i].e_instr);
      chk($sformatf("row%0d_pc2",    i + 1), f_pc_plus2,  tbl[i].e_pc2);
      chk($sformatf("row%0d_valid",  i + 1), f_valid,     tbl[i].e_valid);
      chk($sformatf("row%0d_req",    i + 1), imem_req,    tbl[i].e_req);
      chk($sformatf("row%0d_addr",   i + 1), imem_addr,   tbl[i].e_addr);
      chk($sformatf("row%0d_halted", i + 1), halted,      tbl[i].e_halted);
      stall     = tbl[i].stall;
      branching = tbl[i].branching;
      halt      = tbl[i].halt;
      next_pc   = tbl[i].next_pc;
    end

    // PC wrap at 16'hFFFE, then halt together with branch.
    do_reset();
    branching = 1'b1; next_pc = 16'hFFFE;
    @(negedge clk);
    branching = 1'b0;
    chk("wrap_req",  imem_req,  1'b1);
    chk("wrap_addr", imem_addr, 16'hFFFE);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_instr", instruction, 16'h5A5B);
    chk("wrap_pc2",   f_pc_plus2,  16'h0000);
    chk("wrap_valid", f_valid,     1'b1);
    chk("wrap_naddr", imem_addr,   16'h0000);
    halt = 1'b1; branching = 1'b1; next_pc = 16'h0200;
    @(negedge clk);
    chk("hb_halted", halted,      1'b1);
    chk("hb_req",    imem_req,    1'b0);
    chk("hb_valid",  f_valid,     1'b0);
    chk("hb_instr",  instruction, 16'h0000);
    chk("hb_addr",   imem_addr,   16'h0000);
    halt = 1'b0; next_pc = 16'h0300;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_req", k),    imem_req,  1'b0);
      chk($sformatf("hold%0d_halted", k), halted,    1'b1);
      chk($sformatf("hold%0d_addr", k),   imem_addr, 16'h0000);
      chk($sformatf("hold%0d_valid", k),  f_valid,   1'b0);
    end
    branching = 1'b0;

    // HLT word fetched from 0x0080.
    do_reset();
    branching = 1'b1; next_pc = 16'h0080;
    @(negedge clk);
    branching = 1'b0;
    chk("hlt_addr", imem_addr, 16'h0080);
    @(negedge clk);
    @(negedge clk);
    chk("hlt_instr", instruction, 16'hF000);
    chk("hlt_valid", f_valid,     1'b1);
    chk("hlt_pc2",   f_pc_plus2,  16'h0082);
`ifdef FETCH_HLT_PREDECODE_EN
    chk("hlt_halted", halted,   1'b1);
    chk("hlt_req",    imem_req, 1'b0);
    @(negedge clk);
    chk("hlt_after_valid",  f_valid,  1'b0);
    chk("hlt_after_req",    imem_req, 1'b0);
    chk("hlt_after_halted", halted,   1'b1);
`else
    chk("hlt_halted", halted,    1'b0);
    chk("hlt_req",    imem_req,  1'b1);
    chk("hlt_naddr",  imem_addr, 16'h0082);
    @(negedge clk);
    chk("hlt_after_valid",  f_valid,  1'b0);
    chk("hlt_after_req",    imem_req, 1'b1);
    chk("hlt_after_halted", halted,   1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
